// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the ternary weight stream buffer.
package wbuf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } wbuf_state_e;

    localparam int unsigned WGT_BITS_2 = 2;
    localparam int unsigned WGT_BITS_4 = 4;

    // Weights per load byte; any width other than 4 is treated as the 2-bit encoding.
    function automatic int unsigned wpb(input int unsigned wgt_bits, input int unsigned data_w);
        return (wgt_bits == WGT_BITS_4) ? data_w / WGT_BITS_4 : data_w / WGT_BITS_2;
    endfunction

endpackage

// File: rtl/wbuf_lane_mem.sv
// One lane of packed weight storage: byte-wide single-port RAM, 1-cycle read, write wins.
module wbuf_lane_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WORDS  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (!we_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ternary_weight_stream_buffer.sv
// Lane-major weight image loader plus column-window streamer for the PE array.
// Optional WBUF_NZ_MASK_EN adds a per-lane nonzero mask registered with each column.
module ternary_weight_stream_buffer
    import wbuf_pkg::*;
#(
    parameter int unsigned ARR_WIDTH = 16,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned WGT_BITS  = 2,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ld_start,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          loaded,
    input  logic                          rd_start,
    input  logic [$clog2(DEPTH)-1:0]      rd_base,
    input  logic [$clog2(DEPTH):0]        rd_len,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ARR_WIDTH*WGT_BITS-1:0] out_col,
    output logic [$clog2(DEPTH)-1:0]      out_idx,
    output logic                          rd_done,
    output logic                          err
`ifdef WBUF_NZ_MASK_EN
    ,
    output logic [ARR_WIDTH-1:0]          out_nz
`endif
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam int unsigned WPB     = wpb(WGT_BITS, DATA_W);
    localparam int unsigned WORDS   = DEPTH / WPB;
    localparam int unsigned WORD_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LANE_W  = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
    localparam int unsigned SUB_W   = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned COL_W   = ARR_WIDTH * WGT_BITS;

    typedef logic [COL_W-1:0] col_t;

    wbuf_state_e        state_q, state_d;
    logic               wr_ready_q, wr_ready_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic               rd_done_q, rd_done_d;
    logic [WORD_AW-1:0] word_q, word_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [IDX_W-1:0]   iss_col_q, iss_col_d;
    logic [LEN_W-1:0]   iss_rem_q, iss_rem_d;
    logic [LEN_W-1:0]   hs_left_q, hs_left_d;
    logic               pend_q, pend_d;
    logic [SUB_W-1:0]   pend_sub_q, pend_sub_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic               out_valid_q, out_valid_d;
    col_t               out_col_q, out_col_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               skid_vld_q, skid_vld_d;
    col_t               skid_col_q, skid_col_d;
    logic [IDX_W-1:0]   skid_idx_q, skid_idx_d;
`ifdef WBUF_NZ_MASK_EN
    logic [ARR_WIDTH-1:0] out_nz_q, out_nz_d;
    logic [ARR_WIDTH-1:0] skid_nz_q, skid_nz_d;
    logic [ARR_WIDTH-1:0] nz_c;
`endif

    logic               mem_we_c;
    logic [WORD_AW-1:0] mem_addr_c;
    logic [IDX_W-1:0]   rd_col_c;
    logic               issue_c;
    logic               pop_c;
    logic               head_free_c;
    logic [1:0]         occ_c;
    col_t               col_c;
    logic [DATA_W-1:0]  lane_sh;
    logic [DATA_W-1:0]  rdata_w [ARR_WIDTH];

    for (genvar gi = 0; gi < ARR_WIDTH; gi++) begin : g_lane
        wbuf_lane_mem #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS),
            .AW     (WORD_AW)
        ) u_mem (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (mem_we_c && (lane_q == LANE_W'(gi))),
            .addr_i  (mem_addr_c),
            .wdata_i (wr_data),
            .rdata_o (rdata_w[gi])
        );
    end

    // Unpack the pending column from the lane words; sub-field 0 sits in the MSBs.
    always_comb begin
        col_c   = '0;
        lane_sh = '0;
`ifdef WBUF_NZ_MASK_EN
        nz_c    = '0;
`endif
        for (int i = 0; i < ARR_WIDTH; i++) begin
            lane_sh = rdata_w[i] << (32'(pend_sub_q) * WGT_BITS);
            col_c[i*WGT_BITS +: WGT_BITS] = lane_sh[DATA_W-1 -: WGT_BITS];
`ifdef WBUF_NZ_MASK_EN
            nz_c[i] = |lane_sh[DATA_W-1 -: WGT_BITS];
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        loaded_d    = loaded_q;
        err_d       = 1'b0;
        rd_done_d   = 1'b0;
        word_d      = word_q;
        lane_d      = lane_q;
        iss_col_d   = iss_col_q;
        iss_rem_d   = iss_rem_q;
        hs_left_d   = hs_left_q;
        pend_d      = 1'b0;
        pend_sub_d  = pend_sub_q;
        pend_idx_d  = pend_idx_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_idx_d   = out_idx_q;
        skid_vld_d  = skid_vld_q;
        skid_col_d  = skid_col_q;
        skid_idx_d  = skid_idx_q;
`ifdef WBUF_NZ_MASK_EN
        out_nz_d    = out_nz_q;
        skid_nz_d   = skid_nz_q;
`endif
        mem_we_c    = 1'b0;
        rd_col_c    = iss_col_q;
        issue_c     = 1'b0;
        pop_c       = out_valid_q && out_ready;
        head_free_c = !out_valid_q || pop_c;
        occ_c       = 2'(out_valid_q) + 2'(skid_vld_q) + 2'(pend_q);

        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    loaded_d = 1'b0;
                    word_d   = '0;
                    lane_d   = '0;
                end else if (rd_start) begin
                    if (!loaded_q) begin
                        err_d = 1'b1;
                    end else if (rd_len == '0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        // First read is issued in the request cycle to save a cycle of latency.
                        state_d   = STREAM;
                        issue_c   = 1'b1;
                        rd_col_c  = rd_base;
                        iss_col_d = rd_base + IDX_W'(1);
                        iss_rem_d = rd_len - LEN_W'(1);
                        hs_left_d = rd_len;
                    end
                end
            end
            LOAD: begin
                err_d = rd_start;
                if (ld_start) begin
                    word_d = '0;
                    lane_d = '0;
                end else if (wr_valid) begin
                    mem_we_c = 1'b1;
                    word_d   = word_q + WORD_AW'(1);
                    if (word_q == WORD_AW'(WORDS - 1)) begin
                        lane_d = lane_q + LANE_W'(1);
                        if (lane_q == LANE_W'(ARR_WIDTH - 1)) begin
                            loaded_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
            end
            STREAM: begin
                err_d = ld_start || rd_start;
                // Keep at most two columns between the RAM and the output registers.
                if ((iss_rem_q != '0) && ((occ_c - 2'(pop_c)) < 2'd2)) begin
                    issue_c   = 1'b1;
                    iss_col_d = iss_col_q + IDX_W'(1);
                    iss_rem_d = iss_rem_q - LEN_W'(1);
                end
                if (pop_c) begin
                    hs_left_d = hs_left_q - LEN_W'(1);
                    if (hs_left_q == LEN_W'(1)) begin
                        rd_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_c) begin
            pend_d     = 1'b1;
            pend_sub_d = SUB_W'(rd_col_c % WPB);
            pend_idx_d = rd_col_c;
        end

        mem_addr_c = (state_q == LOAD) ? word_q : WORD_AW'(rd_col_c / WPB);

        // Two-entry output queue: head is the visible column, skid absorbs a stall.
        if (head_free_c) begin
            if (skid_vld_q) begin
                out_valid_d = 1'b1;
                out_col_d   = skid_col_q;
                out_idx_d   = skid_idx_q;
`ifdef WBUF_NZ_MASK_EN
                out_nz_d    = skid_nz_q;
`endif
                skid_vld_d  = pend_q;
                if (pend_q) begin
                    skid_col_d = col_c;
                    skid_idx_d = pend_idx_q;
`ifdef WBUF_NZ_MASK_EN
                    skid_nz_d  = nz_c;
`endif
                end
            end else begin
                out_valid_d = pend_q;
                if (pend_q) begin
                    out_col_d = col_c;
                    out_idx_d = pend_idx_q;
`ifdef WBUF_NZ_MASK_EN
                    out_nz_d  = nz_c;
`endif
                end
            end
        end else if (pend_q) begin
            skid_vld_d = 1'b1;
            skid_col_d = col_c;
            skid_idx_d = pend_idx_q;
`ifdef WBUF_NZ_MASK_EN
            skid_nz_d  = nz_c;
`endif
        end

        wr_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ready_q  <= 1'b0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            rd_done_q   <= 1'b0;
            word_q      <= '0;
            lane_q      <= '0;
            iss_col_q   <= '0;
            iss_rem_q   <= '0;
            hs_left_q   <= '0;
            pend_q      <= 1'b0;
            pend_sub_q  <= '0;
            pend_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_idx_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_col_q  <= '0;
            skid_idx_q  <= '0;
`ifdef WBUF_NZ_MASK_EN
            out_nz_q    <= '0;
            skid_nz_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ready_q  <= wr_ready_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            rd_done_q   <= rd_done_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            iss_col_q   <= iss_col_d;
            iss_rem_q   <= iss_rem_d;
            hs_left_q   <= hs_left_d;
            pend_q      <= pend_d;
            pend_sub_q  <= pend_sub_d;
            pend_idx_q  <= pend_idx_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_idx_q   <= out_idx_d;
            skid_vld_q  <= skid_vld_d;
            skid_col_q  <= skid_col_d;
            skid_idx_q  <= skid_idx_d;
`ifdef WBUF_NZ_MASK_EN
            out_nz_q    <= out_nz_d;
            skid_nz_q   <= skid_nz_d;
`endif
        end
    end

    assign wr_ready  = wr_ready_q;
    assign loaded    = loaded_q;
    assign err       = err_q;
    assign rd_done   = rd_done_q;
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_idx   = out_idx_q;
`ifdef WBUF_NZ_MASK_EN
    assign out_nz    = out_nz_q;
`endif

endmodule

// File: tb/tb_ternary_weight_stream_buffer.sv
// Scoreboard bench for ternary_weight_stream_buffer (default parameters).
module tb_ternary_weight_stream_buffer;

    localparam int unsigned AW = 16;
    localparam int unsigned DP = 64;
    localparam int unsigned WB = 2;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] col;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        ld_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        loaded;
    logic        rd_start;
    logic [5:0]  rd_base;
    logic [6:0]  rd_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic [5:0]  out_idx;
    logic        rd_done;
    logic        err;
`ifdef WBUF_NZ_MASK_EN
    logic [15:0] out_nz;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    logic [7:0]  img [AW][DP/4];

    ternary_weight_stream_buffer #(
        .ARR_WIDTH (AW),
        .DEPTH     (DP),
        .WGT_BITS  (WB),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_start  (ld_start),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .loaded    (loaded),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .rd_done   (rd_done),
        .err       (err)
`ifdef WBUF_NZ_MASK_EN
        ,
        .out_nz    (out_nz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_col(input int c);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int l = 0; l < AW; l++) begin
            b = img[l][c / 4];
            r[l*2 +: 2] = 2'(b >> (6 - 2 * (c % 4)));
        end
        return r;
    endfunction

    task automatic push_model(input int base, input int len);
        int c;
        for (int k = 0; k < len; k++) begin
            c = (base + k) % DP;
            sb_q.push_back('{idx: 6'(c), col: model_col(c)});
        end
    endtask

    // Monitor: pops on every handshake and checks hold stability during stalls.
    logic        stalled = 1'b0;
    logic [31:0] held_col;
    logic [5:0]  held_idx;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_col", 64'(out_col), 64'(held_col));
                check("stall_idx", 64'(out_idx), 64'(held_idx));
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_col", 64'(out_idx), 64'hFFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("col_idx", 64'(out_idx), 64'(mon_e.idx));
                    check("col_data", 64'(out_col), 64'(mon_e.col));
`ifdef WBUF_NZ_MASK_EN
                    for (int l = 0; l < AW; l++) begin
                        check("nz_bit", 64'(out_nz[l]), 64'(|mon_e.col[l*2 +: 2]));
                    end
`endif
                end
            end else if (out_valid) begin
                stalled  = 1'b1;
                held_col = out_col;
                held_idx = out_idx;
            end
        end
    end

    task automatic load_image(input bit ramp, input int abort_at, input int rd_err_at);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        if (abort_at > 0) begin
            for (int n = 0; n < abort_at; n++) begin
                repeat ($urandom_range(0, 2)) tick();
                wr_valid = 1'b1;
                wr_data  = 8'hC3;
                tick();
                wr_valid = 1'b0;
            end
            ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
        end
        check("load_ready", 64'(wr_ready), 64'd1);
        for (int n = 0; n < AW * DP / 4; n++) begin
            img[n / 16][n % 16] = ramp ? 8'((n / 16) * 37 + (n % 16) * 11 + 5) : 8'h1E;
            repeat ($urandom_range(0, 2)) tick();
            if (n == AW * DP / 4 - 1) check("loaded_early", 64'(loaded), 64'd0);
            wr_valid = 1'b1;
            wr_data  = img[n / 16][n % 16];
            if (n == rd_err_at) rd_start = 1'b1;
            tick();
            wr_valid = 1'b0;
            rd_start = 1'b0;
            if (n == rd_err_at) check("err_rd_in_load", 64'(err), 64'd1);
        end
        check("loaded_set", 64'(loaded), 64'd1);
        check("ready_after_load", 64'(wr_ready), 64'd0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic run_stream(input int base, input int len, input int mode, input bit inject_ld);
        bit done;
        out_ready = 1'b1;
        rd_base   = 6'(base);
        rd_len    = 7'(len);
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        if (len == 0) begin
            check("len0_done", 64'(rd_done), 64'd1);
            check("len0_no_valid", 64'(out_valid), 64'd0);
            tick();
            check("len0_done_pulse", 64'(rd_done), 64'd0);
            check("len0_no_valid2", 64'(out_valid), 64'd0);
            return;
        end
        if (mode == 0) begin
            check("first_valid_early", 64'(out_valid), 64'd0);
            if (inject_ld) ld_start = 1'b1;
            tick();
            ld_start = 1'b0;
            if (inject_ld) check("err_ld_in_stream", 64'(err), 64'd1);
            for (int k = 0; k < len; k++) begin
                check("no_bubble", 64'(out_valid), 64'd1);
                tick();
            end
            check("rd_done_pulse", 64'(rd_done), 64'd1);
            check("valid_after_done", 64'(out_valid), 64'd0);
        end else begin
            done = 1'b0;
            for (int j = 0; j < 400 && !done; j++) begin
                out_ready = (j % 3 == 0);
                tick();
                if (rd_done) done = 1'b1;
            end
            check("bp_done_seen", 64'(done), 64'd1);
            out_ready = 1'b1;
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        ld_start  = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_start  = 1'b0;
        rd_base   = '0;
        rd_len    = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_loaded", 64'(loaded), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_col", 64'(out_col), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_rd_done", 64'(rd_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset_n = 1'b1;
        tick();

        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("err_unloaded", 64'(err), 64'd1);
        check("valid_unloaded", 64'(out_valid), 64'd0);
        check("loaded_unloaded", 64'(loaded), 64'd0);
        tick();
        check("err_one_cycle", 64'(err), 64'd0);

        // All bytes 00_01_11_10: columns 0,+1,-1,-2 in every lane.
        load_image(1'b0, 0, -1);
        sb_q.push_back('{idx: 6'd0, col: 32'h0000_0000});
        sb_q.push_back('{idx: 6'd1, col: 32'h5555_5555});
        sb_q.push_back('{idx: 6'd2, col: 32'hFFFF_FFFF});
        sb_q.push_back('{idx: 6'd3, col: 32'hAAAA_AAAA});
        run_stream(0, 4, 0, 1'b0);

        load_image(1'b1, 5, 100);
        push_model(62, 4);
        run_stream(62, 4, 0, 1'b0);
        push_model(5, 8);
        run_stream(5, 8, 1, 1'b0);
        push_model(20, 8);
        run_stream(20, 8, 0, 1'b0);
        run_stream(9, 0, 0, 1'b0);
        push_model(30, 6);
        run_stream(30, 6, 0, 1'b1);
        check("loaded_kept", 64'(loaded), 64'd1);

        // Asynchronous reset while a stalled stream holds a valid column.
        push_model(10, 16);
        out_ready = 1'b0;
        rd_base   = 6'd10;
        rd_len    = 7'd16;
        rd_start  = 1'b1;
        tick();
        rd_start  = 1'b0;
        repeat (4) tick();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_loaded", 64'(loaded), 64'd0);
        sb_q.delete();
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(wr_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
